// File: rtl/mult_sched_if.sv
// Request/response handshake bundle for mult_sched: per-requester operand
// pairs in, one tagged product stream out.
interface mult_sched_if #(
    parameter int NREQ = 4
) ();
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [12*NREQ-1:0] req_a;
    logic [12*NREQ-1:0] req_b;
    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [23:0]        resp_data;

    // The scheduler side: accepts requests, produces responses.
    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data
    );

    // The client side: issues requests, consumes responses.
    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data
    );
endinterface

// File: rtl/mult_sched.sv
// Round-robin scheduler that shares one 12x12 multiplier between NREQ
// requesters. One register stage drives the multiplier; its combinational
// product is captured with the requester id into a small result FIFO.
module mult_sched #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    mult_sched_if.slave bus,
    output logic [11:0] mul_a,
    output logic [11:0] mul_b,
    input  logic [23:0] mul_res,
    output logic        busy
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [23:0]    data;
    } entry_t;

    // Issue stage state
    logic [IDW-1:0] rr_ptr_q,   rr_ptr_d;
    logic [11:0]    mul_a_q,    mul_a_d;
    logic [11:0]    mul_b_q,    mul_b_d;
    logic           s1_valid_q, s1_valid_d;
    logic [IDW-1:0] s1_id_q,    s1_id_d;

    // Result FIFO state
    logic [PW-1:0]  wr_ptr_q,     wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q,     rd_ptr_d;
    logic [CW-1:0]  fifo_count_q, fifo_count_d;
    entry_t         fifo_mem_q [DEPTH];

    // Combinational control
    logic [IDW:0]   cand;
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [11:0]    sel_a;
    logic [11:0]    sel_b;
    logic [CW:0]    occ_next;
    logic           can_issue;
    logic           issue;
    logic           push;
    logic           pop;
    logic [NREQ-1:0] req_ready_c;
    entry_t         head;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later statements see
        // the values computed above them; clocked blocks use '<=' only.
        // NOTE: every output of this block gets a default before any branch,
        // otherwise an unassigned path would infer a latch.
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    // Issue decision and operand mux for the granted requester.
    always_comb begin
        pop      = (fifo_count_q != '0) && bus.resp_ready;
        push     = s1_valid_q;
        // Occupancy the FIFO would have once the op now in s1 lands; the new
        // issue must still find a slot behind it.
        occ_next = {1'b0, fifo_count_q} + (CW+1)'(s1_valid_q) - (CW+1)'(pop);
        can_issue = occ_next < (CW+1)'(DEPTH);
        // Gating with rst_n keeps req_ready low while reset is asserted.
        issue    = grant_found && can_issue && rst_n;

        sel_a       = '0;
        sel_b       = '0;
        req_ready_c = '0;
        for (int g = 0; g < NREQ; g++) begin
            if (grant_idx == IDW'(g)) begin
                sel_a          = bus.req_a[12*g +: 12];
                sel_b          = bus.req_b[12*g +: 12];
                req_ready_c[g] = issue;
            end
        end
    end

    // Next state for the issue stage; operands hold when idle to avoid toggling.
    always_comb begin
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        s1_id_d    = s1_id_q;
        rr_ptr_d   = rr_ptr_q;
        s1_valid_d = issue;
        if (issue) begin
            mul_a_d  = sel_a;
            mul_b_d  = sel_b;
            s1_id_d  = grant_idx;
            rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Next state for FIFO pointers and count; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            s1_valid_q   <= 1'b0;
            s1_id_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    // FIFO storage: capture the product of the op sitting in s1.
    // NOTE: storage is left unreset; nothing reads it unless fifo_count says
    // the slot is live, and the response outputs are forced to zero otherwise.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= '{id: s1_id_q, data: mul_res};
        end
    end

    assign head           = fifo_mem_q[rd_ptr_q];
    assign bus.resp_valid = (fifo_count_q != '0);
    assign bus.resp_id    = bus.resp_valid ? head.id   : '0;
    assign bus.resp_data  = bus.resp_valid ? head.data : '0;
    assign bus.req_ready  = req_ready_c;
    assign mul_a          = mul_a_q;
    assign mul_b          = mul_b_q;
    assign busy           = s1_valid_q || (fifo_count_q != '0);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (fifo_count_q < CW'(DEPTH)));

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready_c));
endmodule

// File: tb/tb_mult_sched.sv
// Bench for mult_sched: table-driven grant sequence, backpressure, pop/issue
// overlap and mid-stream reset; a scoreboard checks every response.
module tb_mult_sched;
    localparam int NREQ  = 4;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] mul_a;
    logic [11:0] mul_b;
    logic [23:0] mul_res;
    logic        busy;

    always #5 clk = ~clk;

    mult_sched_if #(.NREQ(NREQ)) bus ();

    assign mul_res = {mul_a, mul_b};

    mult_sched #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_res (mul_res),
        .busy    (busy)
    );

    typedef struct {
        logic [1:0]  id;
        logic [23:0] data;
    } exp_t;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] exp_ready;
        logic       exp_resp_valid;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[14];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] v);
        bus.req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[12*i +: 12] = 12'($urandom);
            bus.req_b[12*i +: 12] = 12'($urandom);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  32'(bus.req_ready),  32'h0);
        check({tag, "_mul_a"},      32'(mul_a),          32'h0);
        check({tag, "_mul_b"},      32'(mul_b),          32'h0);
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'h0);
        check({tag, "_resp_id"},    32'(bus.resp_id),    32'h0);
        check({tag, "_resp_data"},  32'(bus.resp_data),  32'h0);
        check({tag, "_busy"},       32'(busy),           32'h0);
    endtask

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        bus.resp_ready = 1'b1;
        drive(4'b0000);
        #2;
        while (busy && cyc < 20) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        check({tag, "_drain_done"}, 32'(busy), 32'h0);
        #2;
        check({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'h0);
    endtask

    // Scoreboard monitor: pop/compare on response handshakes, push on request handshakes.
    always @(negedge clk) begin
        #3;
        if (rst_n) begin
            check("ready_onehot", 32'($onehot0(bus.req_ready)), 32'h1);
            if (bus.resp_valid && bus.resp_ready) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_id", 32'(bus.resp_id), 32'(e.id));
                    check("resp_data", 32'(bus.resp_data), 32'(e.data));
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    exp_t e;
                    e.id   = 2'(i);
                    e.data = {bus.req_a[12*i +: 12], bus.req_b[12*i +: 12]};
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_hs;

        // Grant sequence with resp_ready=1; responses appear 2 cycles after handshake.
        vecs[0]  = '{4'b0001, 4'b0001, 1'b0};
        vecs[1]  = '{4'b0000, 4'b0000, 1'b0};
        vecs[2]  = '{4'b0000, 4'b0000, 1'b1};
        vecs[3]  = '{4'b1111, 4'b0010, 1'b0};
        vecs[4]  = '{4'b1111, 4'b0100, 1'b0};
        vecs[5]  = '{4'b1111, 4'b1000, 1'b1};
        vecs[6]  = '{4'b1111, 4'b0001, 1'b1};
        vecs[7]  = '{4'b1001, 4'b1000, 1'b1};
        vecs[8]  = '{4'b1001, 4'b0001, 1'b1};
        vecs[9]  = '{4'b0101, 4'b0100, 1'b1};
        vecs[10] = '{4'b0011, 4'b0001, 1'b1};
        vecs[11] = '{4'b0000, 4'b0000, 1'b1};
        vecs[12] = '{4'b0000, 4'b0000, 1'b1};
        vecs[13] = '{4'b0000, 4'b0000, 1'b0};

        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;

        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven section.
        for (int r = 0; r < 14; r++) begin
            @(negedge clk);
            bus.resp_ready = 1'b1;
            drive(vecs[r].valid);
            if (r == 0) begin
                bus.req_a[11:0] = 12'h00A;
                bus.req_b[11:0] = 12'h003;
            end
            #2;
            check($sformatf("vec%0d_req_ready", r), 32'(bus.req_ready), 32'(vecs[r].exp_ready));
            check($sformatf("vec%0d_resp_valid", r), 32'(bus.resp_valid), 32'(vecs[r].exp_resp_valid));
            if (r == 2) begin
                check("single_resp_id", 32'(bus.resp_id), 32'h0);
                check("single_resp_data", 32'(bus.resp_data), 32'h00A003);
            end
        end

        // Backpressure: requester 2 streams while the consumer stalls.
        n_hs = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            bus.resp_ready = 1'b0;
            drive(4'b0100);
            #2;
            if (bus.req_ready[2]) n_hs++;
            if (j >= 2) begin
                check("bp_resp_valid", 32'(bus.resp_valid), 32'h1);
                check("bp_head_id", 32'(bus.resp_id), 32'(exp_q[0].id));
                check("bp_head_data", 32'(bus.resp_data), 32'(exp_q[0].data));
            end
        end
        check("bp_issue_count", 32'(n_hs), 32'h2);
        check("bp_req_ready_held", 32'(bus.req_ready), 32'h0);
        check("bp_busy", 32'(busy), 32'h1);

        // FIFO full, s1 empty: a pop lets an issue happen in the same cycle.
        @(negedge clk);
        bus.resp_ready = 1'b1;
        drive(4'b0100);
        #2;
        check("pop_issue_ready", 32'(bus.req_ready), 32'h4);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            bus.resp_ready = 1'b0;
            drive(4'b0100);
            #2;
            check("refill_req_ready", 32'(bus.req_ready), 32'h0);
        end
        drain("bp");

        // Mid-stream reset with s1 occupied and one FIFO entry.
        @(negedge clk);
        bus.resp_ready = 1'b0;
        drive(4'b0001);
        #2;
        check("rst_setup_ready0", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        drive(4'b0010);
        #2;
        check("rst_setup_ready1", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        drive(4'b0000);
        #2;
        check("rst_setup_busy", 32'(busy), 32'h1);
        check("rst_setup_resp_valid", 32'(bus.resp_valid), 32'h1);
        #2;
        bus.req_valid = 4'b1111;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        #2;
        check_reset_outputs("held_rst");
        @(negedge clk);
        bus.req_valid  = 4'b0000;
        bus.resp_ready = 1'b1;
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #2;
            check("post_rst_resp_valid", 32'(bus.resp_valid), 32'h0);
            check("post_rst_busy", 32'(busy), 32'h0);
            @(negedge clk);
        end
        drive(4'b1111);
        #2;
        check("post_rst_grant0", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
